// File: rtl/multipli_top.sv
// -----------------------------------------------------------------------------
// multipli_top
//   Sequential signed multiplier using radix-2 Booth recoding. One
//   add/subtract and one arithmetic right shift per clock, so a product
//   takes B_bits iteration cycles plus an INIT and a DONE cycle.
//
// Ports
//   CLK       in   rising-edge clock for all state
//   RESET_N   in   asynchronous active-low reset
//   start     in   request a multiplication (level; one product per assertion)
//   A         in   signed multiplicand, A_bits wide
//   B         in   signed multiplier, B_bits wide
//   S         out  signed product, A_bits+B_bits wide, held until next DONE
//   fin_mult  out  one-cycle pulse, S valid while high
// -----------------------------------------------------------------------------
module multipli_top #(
    parameter int A_bits = 8,
    parameter int B_bits = 8
) (
    input  logic                            CLK,
    input  logic                            RESET_N,
    input  logic                            start,
    input  logic signed [A_bits-1:0]        A,
    input  logic signed [B_bits-1:0]        B,
    output logic signed [A_bits+B_bits-1:0] S,
    output logic                            fin_mult
);

    localparam int CW = $clog2(B_bits + 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] INIT     = 3'd1;
    localparam logic [2:0] ITER     = 3'd2;
    localparam logic [2:0] DONE     = 3'd3;
    localparam logic [2:0] WAIT_LOW = 3'd4;

    logic [2:0]               state_q,  state_d;
    // Multiplicand and accumulator high half carry one extra bit so that
    // subtracting the most negative A never overflows.
    logic [A_bits:0]          mcand_q,  mcand_d;
    logic [A_bits:0]          hi_q,     hi_d;
    logic [B_bits-1:0]        lo_q,     lo_d;
    logic                     qm1_q,    qm1_d;
    logic [CW-1:0]            cnt_q,    cnt_d;
    logic [A_bits+B_bits-1:0] s_q,      s_d;
    logic                     fin_q,    fin_d;

    logic [A_bits:0]          hi_sum;
    logic [A_bits:0]          hi_diff;
    logic [A_bits:0]          hi_op;

    assign hi_sum  = hi_q + mcand_q;
    assign hi_diff = hi_q - mcand_q;

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        fin_d   = 1'b0;
        hi_op   = hi_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                end
            end

            INIT: begin
                mcand_d = {A[A_bits-1], A};
                hi_d    = '0;
                lo_d    = B;
                qm1_d   = 1'b0;
                cnt_d   = CW'(B_bits);
                state_d = ITER;
            end

            ITER: begin
                case ({lo_q[0], qm1_q})
                    2'b10:   hi_op = hi_diff;
                    2'b01:   hi_op = hi_sum;
                    default: hi_op = hi_q;
                endcase
                // Arithmetic shift of {hi, lo, q(-1)}: replicate the sign bit.
                {hi_d, lo_d, qm1_d} = {hi_op[A_bits], hi_op, lo_q};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // The extra high bit is only sign redundancy at this point.
                s_d     = {hi_q[A_bits-1:0], lo_q};
                fin_d   = 1'b1;
                state_d = WAIT_LOW;
            end

            WAIT_LOW: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            fin_q   <= fin_d;
        end
    end

    assign S        = s_q;
    assign fin_mult = fin_q;

endmodule

// File: tb/tb_multipli_top.sv
// -----------------------------------------------------------------------------
// tb_multipli_top
//   Scoreboard bench for multipli_top (8x8). Expected products are pushed
//   when a start is driven and popped when fin_mult is observed.
// -----------------------------------------------------------------------------
module tb_multipli_top;

    localparam int AW = 8;
    localparam int BW = 8;

    logic                      CLK;
    logic                      RESET_N;
    logic                      start;
    logic signed [AW-1:0]      A;
    logic signed [BW-1:0]      B;
    logic signed [AW+BW-1:0]   S;
    logic                      fin_mult;

    int checks = 0;
    int errors = 0;
    int fin_count = 0;

    logic signed [AW+BW-1:0] sb_q[$];
    bit [24:0] cov_hit = '0;

    multipli_top #(.A_bits(AW), .B_bits(BW)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .start    (start),
        .A        (A),
        .B        (B),
        .S        (S),
        .fin_mult (fin_mult)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (fin_mult) fin_count <= fin_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int cls(input logic signed [7:0] x);
        if (x == -8'sd128)   return 0;
        else if (x < 0)      return 1;
        else if (x == 0)     return 2;
        else if (x != 8'sd127) return 3;
        else                 return 4;
    endfunction

    function automatic logic signed [7:0] rnd();
        logic signed [7:0] v;
        case ($urandom_range(0, 7))
            0:       v = -8'sd128;
            1:       v = 8'sd127;
            2:       v = 8'sd0;
            3:       v = -8'sd1;
            default: v = 8'($urandom);
        endcase
        return v;
    endfunction

    // One multiplication; start held for 'hold' edges (>=1).
    task automatic mult(input logic signed [7:0] a, input logic signed [7:0] b, input int hold);
        int n;
        int fc0;
        bit seen;
        logic signed [AW+BW-1:0] expv;
        @(negedge CLK);
        A = a;
        B = b;
        start = 1'b1;
        fc0 = fin_count;
        sb_q.push_back(16'(int'(a) * int'(b)));
        cov_hit[cls(a) * 5 + cls(b)] = 1'b1;
        @(posedge CLK);
        n = 0;
        seen = 0;
        while (!seen && n < 30) begin
            @(negedge CLK);
            n++;
            if (n >= hold) start = 1'b0;
            // Operands change only after INIT has latched them.
            if (n >= 2) begin
                A = 8'($urandom);
                B = 8'($urandom);
            end
            #1;
            if (fin_mult) seen = 1;
        end
        expv = sb_q.pop_front();
        if (!seen) begin
            check("timeout", 32'd0, 32'd1);
        end else begin
            check("prod", S, expv);
            check("latency", n - 1, BW + 2);
            @(negedge CLK);
            n++;
            if (n >= hold) start = 1'b0;
            #1;
            check("pulse_width", fin_mult, 1'b0);
        end
        while (n < hold) begin
            @(negedge CLK);
            n++;
        end
        start = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check("one_pulse", fin_count - fc0, 1);
        check("s_hold", S, expv);
        $display("txn A=%0d B=%0d S=%0d exp=%0d hold=%0d", a, b, S, expv, hold);
    endtask

    // Start a multiplication and reset it 'c' cycles later (c in 1..10).
    task automatic abort(input logic signed [7:0] a, input logic signed [7:0] b, input int c);
        int fc;
        @(negedge CLK);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0;
        repeat (c - 1) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        fc = fin_count;
        check("abort_S", S, 16'd0);
        check("abort_fin", fin_mult, 1'b0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (12) @(negedge CLK);
        #1;
        check("abort_nopulse", fin_count - fc, 0);
        $display("txn abort A=%0d B=%0d after=%0d S=%0d", a, b, c, S);
    endtask

    initial begin
        int hits;
        RESET_N = 1'b0;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        #1;
        check("reset_S", S, 16'd0);
        check("reset_fin", fin_mult, 1'b0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;

        mult(8'sd0,    8'sd96,   1);
        mult(-8'sd45,  8'sd0,    1);
        mult(-8'sd128, -8'sd128, 1);
        mult(8'sd127,  -8'sd128, 1);
        mult(-8'sd1,   -8'sd1,   1);
        mult(8'sd5,    8'sd7,    30);
        abort(8'sd100, 8'sd100,  4);
        mult(-8'sd3,   8'sd9,    1);

        for (int i = 0; i < 220; i++) begin
            if (i % 20 == 10) abort(rnd(), rnd(), $urandom_range(1, 10));
            mult(rnd(), rnd(), (i % 17 == 0) ? 5 : 1);
        end

        hits = 0;
        for (int j = 0; j < 25; j++) if (cov_hit[j]) hits++;
        $display("coverage bins hit %0d of 25", hits);
        check("coverage", (hits * 100 / 25) > 85, 1);
        check("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multipli_top.md
MULTIPLI_TOP -- requirements
Module: multipli_top

Interface
REQ-001 Parameter A_bits, default 8, width of multiplicand A.
REQ-002 Parameter B_bits, default 8, width of multiplier B.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin a multiplication.
REQ-006 A  input  A_bits  signed two's-complement multiplicand.
REQ-007 B  input  B_bits  signed two's-complement multiplier.
REQ-008 S  output  A_bits+B_bits  signed product A*B.
REQ-009 fin_mult  output  1  completion pulse; S valid when high.

Function
REQ-010 Product SHALL be exact signed two's-complement A*B in A_bits+B_bits bits, with no overflow possible.
REQ-011 Implementation SHALL be sequential sum-and-shift (radix-2 Booth), one add/subtract plus one arithmetic right shift per cycle.
- No combinational full multiplier.
REQ-012 FSM states SHALL be IDLE, INIT, ITER, DONE and WAIT_LOW.
REQ-013 IDLE: start=1 sampled at a rising edge -> INIT; otherwise stay in IDLE.
REQ-014 INIT (1 cycle) SHALL perform the following:
- latch A into the multiplicand register;
- load B into the low half of the accumulator;
- clear the high half and the Booth bit q(-1);
- set the iteration counter to B_bits.
REQ-015 ITER (1 cycle per step, B_bits steps) SHALL perform the following:
- examine the pair {acc[0], q(-1)};
- 10: subtract multiplicand from the high half;
- 01: add multiplicand to the high half;
- 00/11: no operation;
- then shift {acc, q(-1)} arithmetically right by 1;
- decrement the counter;
- leave to DONE after the last step.
REQ-016 DONE (1 cycle) SHALL do both of the following:
- load S with the accumulator;
- assert fin_mult.
REQ-017 fin_mult SHALL be high for exactly one clock cycle per multiplication.
REQ-018 Latency: start sampled at edge k -> fin_mult high and S valid from edge k+B_bits+2 (k+10 for 8-bit).
REQ-019 After DONE the FSM SHALL go to WAIT_LOW and stay there while start=1.
- It returns to IDLE when start=0, so a start held high triggers exactly one multiplication.
REQ-020 S SHALL hold its last product until the next DONE or reset.
REQ-021 A and B changes after INIT SHALL NOT affect the running product.
REQ-022 start asserted while not in IDLE SHALL be ignored.
REQ-023 Boundary: A=-2^(A_bits-1) and B=-2^(B_bits-1) SHALL yield +2^(A_bits+B_bits-2).
- An accumulator high part of A_bits+1 bits internally avoids subtract overflow.

Reset
REQ-024 RESET_N=0 SHALL immediately, without waiting for a clock edge, do all of the following:
- force the state to IDLE;
- set S=0 and fin_mult=0;
- clear the accumulator, counter and q(-1).
REQ-025 Reset asserted mid-operation SHALL abort the operation with no fin_mult pulse.
- After release, the block waits in IDLE for a new start.
REQ-026 First rising edge after RESET_N deasserts SHALL be usable for sampling start.

Verification
REQ-027 Zero operand, 8-bit: A=0, B=96, start=1 -> S=0, fin_mult one-cycle pulse 10 cycles after start sampled.
REQ-028 Negative operand times zero, 8-bit: A=-45, B=0 -> S=0.
REQ-029 Extremes, 8-bit:
- A=-128, B=-128 -> S=16384;
- A=127, B=-128 -> S=-16256;
- A=-1, B=-1 -> S=1.
REQ-030 Held start: start held high 30 cycles with A=5, B=7 -> exactly one fin_mult pulse, S=35 and held.
REQ-031 Reset mid-operation: RESET_N low 4 cycles after start -> S=0, fin_mult=0 immediately, no pulse.
- Following start with A=-3, B=9 -> S=-27.
REQ-032 Random regression: at least 200 random signed A/B pairs with start/reset cycling -> S equals the reference signed product every time.
- Functional coverage of operand ranges (negative, zero, positive, extremes) above 85%.
